lockstep_compare_unit: RTL and testbench
========================================

// Module: lockstep_compare_unit
// PURPOSE
// - Successor lockstep checker: compares the trailing core (core1) with the leading core (core0) delayed by DELAY cycles.
// - Adds parametrised widths/depth, per-side valid qualifiers, desync detection, saturating mismatch counter,
//   threshold/sticky fault modes and first-fault capture. Sits between the two cores and the fault/reset controller.
// PARAMETERS
// - DATA_W   32  width of result, rs1, rs2, instr
// - PC_W      8  width of PC
// - DELAY     5  core0-to-core1 skew in cycles, legal 1..16
// - CNT_W     8  mismatch counter width
// - THRESH    1  mismatch count at which fault asserts, 1..2^CNT_W-1
// - STICKY    1  1: fault held until err_clear; 0: fault follows the latest compare
// PORTS
// - clk             in   1        clock, rising edge
// - rst             in   1        asynchronous, active-low reset
// - valid0          in   1        core0 retire strobe
// - result0         in   DATA_W   core0 writeback result
// - pc0             in   PC_W     core0 PC
// - rs1_0, rs2_0    in   DATA_W   core0 operands
// - instr0          in   DATA_W   core0 instruction word
// - valid1, result1, pc1, rs1_1, rs2_1, instr1   in   as core0   core1 equivalents
// - err_clear       in   1        clears fault, counter and capture
// - error_detected  out  1        fault flag
// - desync          out  1        tag mismatch seen (sticky until err_clear)
// - mismatch_cnt    out  CNT_W    saturating count of data mismatches
// - err_pc          out  PC_W     PC of first captured fault
// - err_kind        out  2        00 none, 01 result, 10 instr, 11 both
// BEHAVIOUR
// - Reset (rst=0, async): delay line entries and valid bits 0, all outputs 0, FSM=MONITOR.
// - Delay line: each cycle shifts {valid0,pc0,rs1_0,rs2_0,result0,instr0} in; tail = entry DELAY-1.
// - Compare only when tail.valid && valid1; otherwise no compare, outputs hold (transient mode included).
// - Tag match = pc, rs1, rs2 all equal. Tag match and (result or instr differ) -> data mismatch.
// - Tag mismatch while both valid -> desync<=1; not counted as data mismatch.
// - Only one side valid -> no action (bubble tolerated, no desync).
// - All outputs registered: effect visible one cycle after the inputs that produced the compare.
// - mismatch_cnt: +1 per data mismatch, saturates at all-ones, never wraps.
// - FSM MONITOR->FAULT when post-increment count >= THRESH; err_pc/err_kind captured on that transition only.
// - STICKY=1: FAULT holds error_detected=1 until err_clear. STICKY=0: error_detected=1 on mismatching
//   compare and count>=THRESH, 0 on a matching compare; FSM returns to MONITOR on match.
// - err_clear: counter, desync, err_pc, err_kind, error_detected -> 0, FSM->MONITOR; delay line untouched.
// - err_clear coincident with a mismatch: clear applied first, then the mismatch counts (cnt=1, capture reloads).
// - Reset mid-operation discards in-flight delay-line entries; first compare earliest DELAY cycles after release.
// STRUCTURE
// - Package lockstep_pkg: err_kind encoding constants, FSM state encoding (MONITOR, FAULT), DELAY legal range.
// - Sub-module lockstep_delay_line (WIDTH, DEPTH): valid-tagged shift register, async active-low reset.
// - Top: compare logic, counter, FSM, capture registers.
// TESTING
// - Identical streams, core1 lagging 5 cycles, 100 instrs -> error_detected=0, mismatch_cnt=0, desync=0.
// - result1 XOR 1 at pc=0x20 -> next cycle error_detected=1, mismatch_cnt=1, err_pc=0x20, err_kind=01.
// - THRESH=3, mismatches at pc 0x10,0x14,0x18 -> fault only after third, err_pc=0x18, err_kind per third.
// - STICKY=0: mismatch then matching compare -> error_detected 1 then 0; mismatch_cnt stays 1.
// - pc1 off by 4 with both valid -> desync=1, mismatch_cnt=0; err_clear pulse -> desync=0.
// - err_clear same cycle as instr mismatch -> mismatch_cnt=1, err_kind=10; 300 mismatches -> cnt=0xFF; rst mid-stream -> all 0.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared definitions for the lockstep comparator: fault-kind codes, FSM states
// and the legal range of the core0-to-core1 skew.
package lockstep_pkg;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 16;

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_RESULT = 2'b01;
  localparam logic [1:0] KIND_INSTR  = 2'b10;
  localparam logic [1:0] KIND_BOTH   = 2'b11;

  typedef enum logic {
    ST_MONITOR = 1'b0,
    ST_FAULT   = 1'b1
  } state_e;

  // Out-of-range skews are pinned to the nearest legal depth.
  function automatic int clamp_delay(input int d);
    if (d < DELAY_MIN) return DELAY_MIN;
    if (d > DELAY_MAX) return DELAY_MAX;
    return d;
  endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// Valid-tagged shift register that realigns the leading core's retire record
// with the trailing core; reset drops every in-flight entry.
module lockstep_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/lockstep_compare_unit.sv
// Lockstep checker: compares core1 against core0 delayed by DELAY cycles and
// raises desync, counted data mismatches and a threshold/sticky fault.
module lockstep_compare_unit
  import lockstep_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int DELAY  = 5,
  parameter int CNT_W  = 8,
  parameter int THRESH = 1,
  parameter int STICKY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid0,
  input  logic [DATA_W-1:0] result0,
  input  logic [PC_W-1:0]   pc0,
  input  logic [DATA_W-1:0] rs1_0,
  input  logic [DATA_W-1:0] rs2_0,
  input  logic [DATA_W-1:0] instr0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] result1,
  input  logic [PC_W-1:0]   pc1,
  input  logic [DATA_W-1:0] rs1_1,
  input  logic [DATA_W-1:0] rs2_1,
  input  logic [DATA_W-1:0] instr1,
  input  logic              err_clear,
  output logic              error_detected,
  output logic              desync,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [PC_W-1:0]   err_pc,
  output logic [1:0]        err_kind,
  output state_e            dbg_state
);

  localparam int PAYLOAD_W = PC_W + 4 * DATA_W;
  localparam int DEPTH     = clamp_delay(DELAY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic                 w_t_valid;
  logic [PAYLOAD_W-1:0] w_tail;
  logic [PC_W-1:0]      w_t_pc;
  logic [DATA_W-1:0]    w_t_rs1, w_t_rs2, w_t_res, w_t_ins;

  lockstep_delay_line #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_delay_line (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (valid0),
    .i_data  ({pc0, rs1_0, rs2_0, result0, instr0}),
    .o_valid (w_t_valid),
    .o_data  (w_tail)
  );

  assign {w_t_pc, w_t_rs1, w_t_rs2, w_t_res, w_t_ins} = w_tail;

  logic       w_both, w_tag_match, w_res_diff, w_ins_diff;
  logic       w_data_mm, w_desync_ev, w_match;
  logic [1:0] w_kind;

  // A compare happens only when both sides retire in the same cycle.
  assign w_both      = w_t_valid && valid1;
  assign w_tag_match = (w_t_pc == pc1) && (w_t_rs1 == rs1_1) && (w_t_rs2 == rs2_1);
  assign w_res_diff  = (w_t_res != result1);
  assign w_ins_diff  = (w_t_ins != instr1);
  assign w_data_mm   = w_both && w_tag_match && (w_res_diff || w_ins_diff);
  assign w_desync_ev = w_both && !w_tag_match;
  assign w_match     = w_both && w_tag_match && !w_res_diff && !w_ins_diff;
  assign w_kind      = w_res_diff ? (w_ins_diff ? KIND_BOTH : KIND_RESULT)
                                  : (w_ins_diff ? KIND_INSTR : KIND_NONE);

  logic [CNT_W-1:0] r_cnt, w_cnt_base, w_cnt_next;

  // err_clear takes effect before a coincident mismatch is counted.
  always_comb begin
    w_cnt_base = err_clear ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_data_mm && (w_cnt_base != CNT_MAX)) begin
      w_cnt_next = w_cnt_base + 1'b1;
    end
  end

  state_e r_state, w_state_base, w_state_next;
  logic   w_capture;

  always_comb begin
    w_state_base = err_clear ? ST_MONITOR : r_state;
    w_state_next = w_state_base;
    w_capture    = 1'b0;
    case (w_state_base)
      ST_MONITOR: begin
        if (w_data_mm && (w_cnt_next >= THRESH_C)) begin
          w_state_next = ST_FAULT;
          w_capture    = 1'b1;
        end
      end
      ST_FAULT: begin
        if ((STICKY == 0) && w_match) begin
          w_state_next = ST_MONITOR;
        end
      end
      default: w_state_next = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_MONITOR;
    end else begin
      r_state <= w_state_next;
    end
  end

  logic            r_err, r_desync;
  logic [PC_W-1:0] r_err_pc;
  logic [1:0]      r_err_kind;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_desync   <= 1'b0;
      r_err_pc   <= '0;
      r_err_kind <= KIND_NONE;
    end else begin
      r_cnt    <= w_cnt_next;
      r_err    <= (w_state_next == ST_FAULT);
      r_desync <= (r_desync && !err_clear) || w_desync_ev;
      if (w_capture) begin
        r_err_pc   <= w_t_pc;
        r_err_kind <= w_kind;
      end else if (err_clear) begin
        r_err_pc   <= '0;
        r_err_kind <= KIND_NONE;
      end
    end
  end

  assign error_detected = r_err;
  assign desync         = r_desync;
  assign mismatch_cnt   = r_cnt;
  assign err_pc         = r_err_pc;
  assign err_kind       = r_err_kind;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_lockstep_compare_unit.sv
// Bench for lockstep_compare_unit: three configurations (sticky THRESH=1,
// sticky THRESH=3, non-sticky THRESH=1) share one stimulus stream.
module tb_lockstep_compare_unit;
  import lockstep_pkg::*;

  localparam int DELAY = 5;
  localparam int NDUT  = 3;
  localparam int MAXN  = 320;

  typedef struct packed {
    logic        v;
    logic [7:0]  pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic [31:0] ins;
  } txn_t;

  // clock / reset
  logic clk;
  logic rst;
  logic err_clear;
  txn_t in0, in1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       err_o    [NDUT];
  logic       desync_o [NDUT];
  logic [7:0] cnt_o    [NDUT];
  logic [7:0] epc_o    [NDUT];
  logic [1:0] kind_o   [NDUT];
  state_e     st_o     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lockstep_compare_unit #(
      .DATA_W (32), .PC_W (8), .DELAY (DELAY), .CNT_W (8),
      .THRESH ((g == 1) ? 3 : 1),
      .STICKY ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .valid0         (in0.v),
      .result0        (in0.res),
      .pc0            (in0.pc),
      .rs1_0          (in0.rs1),
      .rs2_0          (in0.rs2),
      .instr0         (in0.ins),
      .valid1         (in1.v),
      .result1        (in1.res),
      .pc1            (in1.pc),
      .rs1_1          (in1.rs1),
      .rs2_1          (in1.rs2),
      .instr1         (in1.ins),
      .err_clear      (err_clear),
      .error_detected (err_o[g]),
      .desync         (desync_o[g]),
      .mismatch_cnt   (cnt_o[g]),
      .err_pc         (epc_o[g]),
      .err_kind       (kind_o[g]),
      .dbg_state      (st_o[g])
    );
  end

  // reference model: core0 records wait DELAY cycles in a queue
  int   thr [NDUT] = '{1, 3, 1};
  bit   stk [NDUT] = '{1, 1, 0};
  int   m_cnt [NDUT];
  bit   m_err [NDUT];
  bit   m_desync [NDUT];
  int   m_pc [NDUT];
  int   m_kind [NDUT];
  txn_t hist[$];

  int checks;
  int errors;

  txn_t src [MAXN];
  int   fk  [MAXN];

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_cnt[d] = 0; m_err[d] = 0; m_desync[d] = 0; m_pc[d] = 0; m_kind[d] = 0;
    end
    hist.delete();
    repeat (DELAY) hist.push_back('0);
  endtask

  task automatic model_edge();
    txn_t p;
    bit   rd, id;
    p = hist.pop_front();
    hist.push_back(in0);
    for (int d = 0; d < NDUT; d++) begin
      if (err_clear) begin
        m_cnt[d] = 0; m_err[d] = 0; m_desync[d] = 0; m_pc[d] = 0; m_kind[d] = 0;
      end
      if (p.v && in1.v) begin
        rd = (p.res != in1.res);
        id = (p.ins != in1.ins);
        if (p.pc != in1.pc || p.rs1 != in1.rs1 || p.rs2 != in1.rs2) begin
          m_desync[d] = 1;
        end else if (rd || id) begin
          if (m_cnt[d] < 255) m_cnt[d]++;
          if (!m_err[d] && m_cnt[d] >= thr[d]) begin
            m_err[d]  = 1;
            m_pc[d]   = p.pc;
            m_kind[d] = (rd ? 1 : 0) + (id ? 2 : 0);
          end
        end else if (!stk[d]) begin
          m_err[d] = 0;
        end
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s_d%0d_err", tag, d),    32'(err_o[d]),    32'(m_err[d]));
      chk($sformatf("%s_d%0d_desync", tag, d), 32'(desync_o[d]), 32'(m_desync[d]));
      chk($sformatf("%s_d%0d_cnt", tag, d),    32'(cnt_o[d]),    32'(m_cnt[d]));
      chk($sformatf("%s_d%0d_pc", tag, d),     32'(epc_o[d]),    32'(m_pc[d]));
      chk($sformatf("%s_d%0d_kind", tag, d),   32'(kind_o[d]),   32'(m_kind[d]));
      chk($sformatf("%s_d%0d_state", tag, d),  32'(st_o[d]),     32'(m_err[d] ? ST_FAULT : ST_MONITOR));
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic gen(input int n, input bit rnd);
    for (int i = 0; i < MAXN; i++) begin
      src[i].v   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      src[i].pc  = rnd ? 8'($urandom) : 8'(4 * i);
      src[i].rs1 = $urandom;
      src[i].rs2 = $urandom;
      src[i].res = $urandom;
      src[i].ins = $urandom;
      fk[i]      = (rnd && $urandom_range(0, 6) == 0) ? int'($urandom_range(1, 4)) : 0;
    end
    if (n > MAXN) $fatal(1, "FAIL gen length %0d exceeds %0d", n, MAXN);
  endtask

  task automatic run(input int n, input int clr_idx, input bit rnd, input int stop);
    for (int k = 0; k < n + DELAY && k < stop; k++) begin
      in0 = (k < n) ? src[k] : '0;
      if (k >= DELAY) begin
        in1 = src[k-DELAY];
        case (fk[k-DELAY])
          1: in1.res = in1.res ^ 32'h1;
          2: in1.ins = in1.ins ^ 32'h1;
          3: begin in1.res = in1.res ^ 32'h1; in1.ins = in1.ins ^ 32'h1; end
          4: in1.pc = in1.pc + 8'd4;
          default: ;
        endcase
        if (rnd && $urandom_range(0, 9) == 0) in1.v = 1'b0;
      end else begin
        in1 = {1'b1, 8'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      end
      err_clear = (k >= DELAY && (k - DELAY) == clr_idx) || (rnd && $urandom_range(0, 19) == 0);
      step();
    end
    err_clear = 1'b0;
    in0 = '0;
    in1 = '0;
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; err_clear = 1'b0; in0 = '0; in1 = '0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // identical streams, 100 instructions
    gen(100, 0);
    run(100, -1, 0, MAXN);
    chk("ident_err", 32'(err_o[0]), 0);
    chk("ident_cnt", 32'(cnt_o[0]), 0);
    chk("ident_desync", 32'(desync_o[0]), 0);

    // single result mismatch at pc 0x20
    gen(30, 0);
    fk[8] = 1;
    run(30, -1, 0, MAXN);
    chk("res_err", 32'(err_o[0]), 1);
    chk("res_cnt", 32'(cnt_o[0]), 1);
    chk("res_pc", 32'(epc_o[0]), 32'h20);
    chk("res_kind", 32'(kind_o[0]), 32'h1);
    chk("res_t3_err", 32'(err_o[1]), 0);
    chk("res_ns_err", 32'(err_o[2]), 0);
    chk("res_ns_cnt", 32'(cnt_o[2]), 1);
    clear_pulse();
    chk("clr_err", 32'(err_o[0]), 0);
    chk("clr_cnt", 32'(cnt_o[0]), 0);
    chk("clr_pc", 32'(epc_o[0]), 0);

    // three mismatches against THRESH=3
    gen(30, 0);
    fk[4] = 1; fk[5] = 1; fk[6] = 2;
    run(30, -1, 0, MAXN);
    chk("t3_err", 32'(err_o[1]), 1);
    chk("t3_cnt", 32'(cnt_o[1]), 3);
    chk("t3_pc", 32'(epc_o[1]), 32'h18);
    chk("t3_kind", 32'(kind_o[1]), 32'h2);
    chk("t1_pc", 32'(epc_o[0]), 32'h10);
    clear_pulse();

    // tag mismatch -> desync only
    gen(20, 0);
    fk[3] = 4;
    run(20, -1, 0, MAXN);
    chk("desync_set", 32'(desync_o[0]), 1);
    chk("desync_cnt", 32'(cnt_o[0]), 0);
    chk("desync_err", 32'(err_o[0]), 0);
    clear_pulse();
    chk("desync_clr", 32'(desync_o[0]), 0);

    // err_clear coincident with an instr mismatch
    gen(20, 0);
    fk[2] = 1; fk[6] = 2;
    run(20, 6, 0, MAXN);
    chk("coinc_cnt", 32'(cnt_o[0]), 1);
    chk("coinc_kind", 32'(kind_o[0]), 32'h2);
    chk("coinc_pc", 32'(epc_o[0]), 32'h18);
    clear_pulse();

    // counter saturation
    gen(300, 0);
    for (int i = 0; i < 300; i++) fk[i] = 1;
    run(300, -1, 0, MAXN);
    chk("sat_cnt0", 32'(cnt_o[0]), 32'hFF);
    chk("sat_cnt2", 32'(cnt_o[2]), 32'hFF);
    clear_pulse();

    // randomized traffic with bubbles, faults and clears
    gen(250, 1);
    run(250, -1, 1, MAXN);

    // reset in the middle of a stream
    gen(40, 0);
    fk[2] = 1;
    run(40, -1, 0, 20);
    rst = 1'b0;
    in0 = '0; in1 = '0;
    #1;
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_cnt", 32'(cnt_o[0]), 0);
    chk("mid_rst_err", 32'(err_o[0]), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    gen(40, 0);
    run(40, -1, 0, MAXN);
    chk("post_rst_err", 32'(err_o[0]), 0);
    chk("post_rst_desync", 32'(desync_o[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
